// File: rtl/vector_stream_tx_if.sv
// vector_stream_tx_if: write/commit port plus outgoing word stream of the
// ping-pong vector source.
//   wr_en/wr_addr/wr_data : word write into the fill bank
//   commit                : hand the fill bank to the transmit side
//   wr_ready              : fill bank is free for writes/commit
//   m_valid/m_ready       : outgoing word handshake
//   data_out/m_last       : outgoing signed word, last-word marker
// Modport master is the source block; slave is the upstream writer and
// downstream consumer seen together.
interface vector_stream_tx_if #(
    parameter int N    = 5,
    parameter int T    = 9,
    parameter int logN = $clog2(N + 1)
) ();
    logic                wr_en;
    logic [logN-1:0]     wr_addr;
    logic signed [T-1:0] wr_data;
    logic                commit;
    logic                wr_ready;
    logic                m_valid;
    logic                m_ready;
    logic signed [T-1:0] data_out;
    logic                m_last;

    modport master (
        input  wr_en, wr_addr, wr_data, commit, m_ready,
        output wr_ready, m_valid, data_out, m_last
    );

    modport slave (
        output wr_en, wr_addr, wr_data, commit, m_ready,
        input  wr_ready, m_valid, data_out, m_last
    );
endinterface

// File: rtl/vector_stream_tx.sv
// vector_stream_tx: ping-pong vector source. Upstream fills one bank by
// address and commits it; the transmit side streams committed banks one word
// per cycle over valid/ready, back-to-back without a bubble.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : vector_stream_tx_if.master (write/commit port, word stream)
module vector_stream_tx #(
    parameter int N    = 5,
    parameter int T    = 9,
    parameter int logN = $clog2(N + 1)
) (
    input  logic               clk,
    input  logic               reset,
    vector_stream_tx_if.master bus
);
    localparam logic [logN-1:0] N_IDX    = logN'(N);
    localparam logic [logN-1:0] LAST_IDX = logN'(N - 1);
    localparam logic [logN-1:0] ONE_IDX  = logN'(1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state;
    logic signed [T-1:0] bank [2][N];
    logic [1:0]          full;
    logic [1:0]          full_next;
    logic                fill_sel;
    logic                send_sel;
    logic [logN-1:0]     rd_idx;
    logic                wr_ok;
    logic                commit_ok;
    logic                release_last;
    logic                m_valid_q;
    logic                m_last_q;
    logic signed [T-1:0] data_q;

    // Ready is taken from the pre-release flags, so a bank freed this cycle
    // only accepts writes/commit from the next cycle on.
    assign wr_ok        = !full[fill_sel];
    assign commit_ok    = bus.commit && wr_ok;
    assign release_last = (state == SEND) && m_valid_q && bus.m_ready && m_last_q;

    assign bus.wr_ready = wr_ok;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_last   = m_last_q;
    assign bus.data_out = data_q;

    // Set and clear never target the same bank: a commit needs the fill bank
    // empty, a release needs the send bank full.
    always_comb begin
        full_next = full;
        if (release_last) full_next[send_sel] = 1'b0;
        if (commit_ok)    full_next[fill_sel] = 1'b1;
    end

    // Bank storage has no reset; a write in the commit cycle lands in the
    // bank being committed.
    always_ff @(posedge clk) begin
        if (!reset && bus.wr_en && wr_ok && (bus.wr_addr < N_IDX))
            bank[fill_sel][bus.wr_addr] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            full      <= '0;
            fill_sel  <= 1'b0;
            send_sel  <= 1'b0;
            rd_idx    <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            data_q    <= '0;
        end else begin
            full <= full_next;
            if (commit_ok) fill_sel <= ~fill_sel;

            case (state)
                IDLE: begin
                    if (full[send_sel]) begin
                        data_q    <= bank[send_sel][0];
                        rd_idx    <= ONE_IDX;
                        m_valid_q <= 1'b1;
                        m_last_q  <= (N == 1);
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (m_valid_q && bus.m_ready) begin
                        if (m_last_q) begin
                            send_sel <= ~send_sel;
                            // Other bank already committed: start it at once.
                            if (full[!send_sel]) begin
                                data_q   <= bank[!send_sel][0];
                                rd_idx   <= ONE_IDX;
                                m_last_q <= (N == 1);
                            end else begin
                                m_valid_q <= 1'b0;
                                m_last_q  <= 1'b0;
                                data_q    <= '0;
                                rd_idx    <= '0;
                                state     <= IDLE;
                            end
                        end else begin
                            data_q   <= bank[send_sel][rd_idx];
                            rd_idx   <= rd_idx + ONE_IDX;
                            m_last_q <= (rd_idx == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_stream_tx.sv
module tb_vector_stream_tx;
    localparam int N = 5;
    localparam int T = 9;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vector_stream_tx_if #(.N(N), .T(T)) bus ();

    vector_stream_tx #(.N(N), .T(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model: committed vectors become a FIFO of expected words; the fill
    // bank is chosen by commit parity since reset; at most two vectors can be
    // outstanding, so the writer is ready whenever fewer than two are.
    typedef struct {
        int   d;
        logic l;
    } word_t;

    int    mbank [2][N];
    word_t expq[$];
    int    commit_count = 0;
    int    inflight = 0;
    int    rxlog[$];
    logic  rxlast[$];

    logic  prev_stall = 1'b0;
    int    prev_data = 0;
    logic  prev_last = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Compare process: samples on the falling edge, between driver updates.
    always @(negedge clk) begin
        logic  ready_pre;
        word_t w;
        if (reset) begin
            expq.delete();
            inflight     = 0;
            commit_count = 0;
            prev_stall   = 1'b0;
        end else begin
            ready_pre = (inflight < 2);
            check("wr_ready", int'(bus.wr_ready), int'(ready_pre));
            if (prev_stall) begin
                check("stall valid", int'(bus.m_valid), 1);
                check("stall data", int'(bus.data_out), prev_data);
                check("stall last", int'(bus.m_last), int'(prev_last));
            end
            if (bus.m_valid === 1'b0) begin
                check("idle data", int'(bus.data_out), 0);
                check("idle last", int'(bus.m_last), 0);
            end
            if (bus.m_valid && bus.m_ready) begin
                rxlog.push_back(int'(bus.data_out));
                rxlast.push_back(bus.m_last);
                if (expq.size() == 0) begin
                    note_fail("unexpected word");
                end else begin
                    w = expq.pop_front();
                    check("word data", int'(bus.data_out), w.d);
                    check("word last", int'(bus.m_last), int'(w.l));
                    if (w.l) inflight--;
                end
            end
            if (bus.wr_en && ready_pre && int'(bus.wr_addr) < N)
                mbank[commit_count % 2][int'(bus.wr_addr)] = int'(bus.wr_data);
            if (bus.commit && ready_pre) begin
                for (int i = 0; i < N; i++)
                    expq.push_back('{d: mbank[commit_count % 2][i], l: (i == N - 1)});
                commit_count++;
                inflight++;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = int'(bus.data_out);
            prev_last  = bus.m_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input int data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'(addr);
        bus.wr_data = 9'(data);
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic write_vec(input int v[$]);
        for (int i = 0; i < v.size(); i++) wr(i, v[i]);
    endtask

    task automatic do_commit();
        bus.commit = 1'b1;
        step();
        bus.commit = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (!(expq.size() == 0 && bus.m_valid === 1'b0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) note_fail(name);
    endtask

    task automatic check_rx(input string name, input int exp[$]);
        check({name, " count"}, rxlog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rxlog.size(); i++) begin
            check({name, " data"}, rxlog[i], exp[i]);
            check({name, " last"}, int'(rxlast[i]), int'((i % N) == N - 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pat[6] = '{1, 0, 0, 1, 0, 1};
        int e[$];
        int n;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.commit  = 1'b0;
        bus.m_ready = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < N; i++) mbank[b][i] = 0;

        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("reset m_valid", int'(bus.m_valid), 0);
        check("reset m_last", int'(bus.m_last), 0);
        check("reset data_out", int'(bus.data_out), 0);
        check("reset wr_ready", int'(bus.wr_ready), 1);

        // 1: single vector, latency and full-rate streaming
        rxlog.delete(); rxlast.delete();
        bus.m_ready = 1'b1;
        write_vec('{1, 2, 3, 4, 5});
        do_commit();
        check("t1 valid at t+1", int'(bus.m_valid), 0);
        step();
        for (int i = 0; i < N; i++) begin
            check("t1 valid", int'(bus.m_valid), 1);
            check("t1 data", int'(bus.data_out), i + 1);
            check("t1 last", int'(bus.m_last), int'(i == N - 1));
            step();
        end
        check("t1 valid after", int'(bus.m_valid), 0);
        e = '{1, 2, 3, 4, 5};
        check_rx("t1 rx", e);

        // 2: backpressure pattern
        rxlog.delete(); rxlast.delete();
        write_vec('{1, 2, 3, 4, 5});
        do_commit();
        n = 0;
        while (!(expq.size() == 0 && bus.m_valid === 1'b0) && n < 60) begin
            bus.m_ready = pat[n % 6][0];
            step();
            n++;
        end
        if (n >= 60) note_fail("t2 drain");
        check_rx("t2 rx", e);

        // 3: two vectors back-to-back, no bubble
        rxlog.delete(); rxlast.delete();
        bus.m_ready = 1'b0;
        write_vec('{1, 2, 3, 4, 5});
        do_commit();
        write_vec('{-1, -2, -3, -4, -5});
        do_commit();
        bus.m_ready = 1'b1;
        e = '{1, 2, 3, 4, 5, -1, -2, -3, -4, -5};
        for (int i = 0; i < 2 * N; i++) begin
            check("t3 no gap", int'(bus.m_valid), 1);
            check("t3 data", int'(bus.data_out), e[i]);
            step();
        end
        check("t3 valid after", int'(bus.m_valid), 0);
        check_rx("t3 rx", e);

        // 4: both banks full, ignored commit/write, freed bank reuse
        rxlog.delete(); rxlast.delete();
        bus.m_ready = 1'b0;
        write_vec('{10, 11, 12, 13, 14});
        do_commit();
        write_vec('{20, 21, 22, 23, 24});
        do_commit();
        check("t4 wr_ready full", int'(bus.wr_ready), 0);
        bus.commit  = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd0;
        bus.wr_data = 9'd9;
        step();
        bus.commit  = 1'b0;
        bus.wr_en   = 1'b0;
        check("t4 wr_ready still full", int'(bus.wr_ready), 0);
        bus.m_ready = 1'b1;
        n = 0;
        while (rxlog.size() < N && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) note_fail("t4 drain A");
        check("t4 wr_ready after A", int'(bus.wr_ready), 1);
        check("t4 B word0 follows", int'(bus.data_out), 20);
        for (int i = 1; i < N; i++) wr(i, 30 + i);
        do_commit();
        drain("t4 drain", 60);
        e = '{10, 11, 12, 13, 14, 20, 21, 22, 23, 24, 10, 31, 32, 33, 34};
        check_rx("t4 rx", e);

        // 5: out-of-range addresses ignored
        rxlog.delete(); rxlast.delete();
        wr(5, -256);
        wr(6, -256);
        wr(7, -256);
        write_vec('{100, -100, 50, -50, 0});
        wr(5, -256);
        do_commit();
        drain("t5 drain", 40);
        e = '{100, -100, 50, -50, 0};
        check_rx("t5 rx", e);

        // 6: reset mid-vector with a second vector committed
        bus.m_ready = 1'b0;
        write_vec('{1, 2, 3, 4, 5});
        do_commit();
        write_vec('{-1, -2, -3, -4, -5});
        do_commit();
        bus.m_ready = 1'b1;
        n = 0;
        while (!(bus.m_valid === 1'b1 && bus.data_out == 9'sd3) && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) note_fail("t6 wait word 3");
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6 m_valid", int'(bus.m_valid), 0);
        check("t6 data_out", int'(bus.data_out), 0);
        check("t6 m_last", int'(bus.m_last), 0);
        check("t6 wr_ready", int'(bus.wr_ready), 1);
        step();
        check("t6 no stale valid", int'(bus.m_valid), 0);
        rxlog.delete(); rxlast.delete();
        write_vec('{7, 8, 9, 10, 11});
        do_commit();
        drain("t6 drain", 40);
        e = '{7, 8, 9, 10, 11};
        check_rx("t6 rx", e);

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
